// File: rtl/mem32x8_master_pkg.sv
// Shared definitions for the mem32x8 bus: default widths, one-hot FSM state codes
// and the legal range check for the strobe timing parameters.
package mem32x8_master_pkg;

  localparam int MEM_AWIDTH = 5;
  localparam int MEM_DWIDTH = 8;
  localparam int CNT_W      = 4;

  localparam logic [5:0] ST_IDLE    = 6'b000001;
  localparam logic [5:0] ST_SETUP   = 6'b000010;
  localparam logic [5:0] ST_WSTROBE = 6'b000100;
  localparam logic [5:0] ST_WHOLD   = 6'b001000;
  localparam logic [5:0] ST_RWAIT   = 6'b010000;
  localparam logic [5:0] ST_DONE    = 6'b100000;

  // Strobe lengths must fit the 4-bit down-counter and be at least one cycle.
  function automatic bit cycles_ok(input int cycles);
    return (cycles >= 1) && (cycles <= 15);
  endfunction

endpackage

// File: rtl/mem32x8_master_if.sv
// Request/ack handshake plus the memory address and strobe lines of the mem32x8 master.
interface mem32x8_master_if
  import mem32x8_master_pkg::*;
#(
  parameter int AWIDTH = MEM_AWIDTH,
  parameter int DWIDTH = MEM_DWIDTH
);

  logic              req;
  logic              we;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] wdata;
  logic              busy;
  logic              ack;
  logic [DWIDTH-1:0] rdata;
  logic [AWIDTH-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;

  modport master (
    input  req, we, req_addr, wdata,
    output busy, ack, rdata, mem_addr, mem_read, mem_write
  );

  modport slave (
    output req, we, req_addr, wdata,
    input  busy, ack, rdata, mem_addr, mem_read, mem_write
  );

endinterface

// File: rtl/mem32x8_master.sv
// Single-transaction master for the mem32x8 strobe interface: turns a req/ack handshake
// into registered, correctly sequenced read/write strobes and owns the data bus direction.
module mem32x8_master
  import mem32x8_master_pkg::*;
#(
  parameter int AWIDTH        = MEM_AWIDTH,
  parameter int DWIDTH        = MEM_DWIDTH,
  parameter int STROBE_CYCLES = 1,
  parameter int READ_WAIT     = 1
) (
  input  logic              clk,
  input  logic              rst_,
  mem32x8_master_if.master  bus,
  // The shared data net stays a plain port so both tri-state drivers meet on one wire.
  inout  wire  [DWIDTH-1:0] mem_data
);

  if (!cycles_ok(STROBE_CYCLES)) begin : g_bad_strobe_cycles
    $error("mem32x8_master: STROBE_CYCLES=%0d outside 1..15", STROBE_CYCLES);
  end
  if (!cycles_ok(READ_WAIT)) begin : g_bad_read_wait
    $error("mem32x8_master: READ_WAIT=%0d outside 1..15", READ_WAIT);
  end

  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES);
  localparam logic [CNT_W-1:0] READ_LOAD   = CNT_W'(READ_WAIT);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(1);

  logic [5:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              ack_q, ack_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              drive_en_q, drive_en_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.req_addr;
          wdata_d = bus.wdata;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (we_q) begin
          state_d = ST_WSTROBE;
          cnt_d   = STROBE_LOAD;
        end else begin
          state_d = ST_RWAIT;
          cnt_d   = READ_LOAD;
        end
      end
      ST_WSTROBE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_WHOLD;
        end else begin
          cnt_d = cnt_q - CNT_LAST;
        end
      end
      ST_WHOLD: state_d = ST_DONE;
      ST_RWAIT: begin
        // Sample the bus on the edge that closes the final read-wait cycle.
        if (cnt_q == CNT_LAST) begin
          rdata_d = mem_data;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_LAST;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode the next state so every strobe comes straight from a flop.
  always_comb begin
    busy_d      = (state_d != ST_IDLE);
    ack_d       = (state_d == ST_DONE);
    mem_write_d = (state_d == ST_WSTROBE);
    mem_read_d  = (state_d == ST_RWAIT);
    drive_en_d  = we_d && ((state_d == ST_SETUP) || (state_d == ST_WSTROBE) ||
                           (state_d == ST_WHOLD));
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      drive_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      drive_en_q  <= drive_en_d;
    end
  end

  assign mem_data      = drive_en_q ? wdata_q : {DWIDTH{1'bz}};
  assign bus.busy      = busy_q;
  assign bus.ack       = ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;

  a_strobes_exclusive : assert property (@(posedge clk) disable iff (!rst_)
    !(mem_read_q && mem_write_q));
  a_no_bus_contention : assert property (@(posedge clk) disable iff (!rst_)
    !(drive_en_q && mem_read_q));
  a_ack_single_cycle : assert property (@(posedge clk) disable iff (!rst_)
    ack_q |=> !ack_q);

endmodule

// File: doc/mem32x8_master.md
Name: mem32x8_master

Overview:
- Synchronous bus master that performs single read/write transactions on the mem32x8 asynchronous strobe interface: addr, read, write, and a shared bidirectional 8-bit data bus.
- Sits between the CPU controller and mem32x8.
- Converts a one-cycle req/ack handshake into glitch-free, correctly sequenced memory strobes.
- Owns data-bus direction so the master and the memory never drive the bus together.

Parameters:
- AWIDTH, 5, address width (32 locations).
- DWIDTH, 8, data width.
- STROBE_CYCLES, 1, clock cycles mem_write is held high; legal range 1..15.
- READ_WAIT, 1, clock cycles mem_read is held high before rdata capture; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_  input  1  asynchronous, active-low reset.
- req  input  1  transaction request; sampled only in IDLE.
- we  input  1  1 = write, 0 = read; sampled with req.
- req_addr  input  AWIDTH  transaction address; sampled with req.
- wdata  input  DWIDTH  write data; sampled with req.
- busy  output  1  high whenever state is not IDLE.
- ack  output  1  one-cycle completion pulse.
- rdata  output  DWIDTH  read result; valid from ack until the next read's ack.
- mem_addr  output  AWIDTH  memory address.
- mem_read  output  1  memory read strobe (memory drives mem_data while high).
- mem_write  output  1  memory write strobe (memory captures on rising edge).
- mem_data  inout  DWIDTH  shared data bus.

Behaviour:
- Reset (async, rst_ low):
  - State goes to IDLE.
  - busy, ack, mem_read, mem_write = 0.
  - rdata, mem_addr = 0.
  - mem_data is released (all Z) immediately, not at the next clock edge.
- Outputs are registered: busy, ack, mem_read, mem_write, mem_addr, rdata come from flops, not from a state decode, so strobes are glitch-free.
- States: IDLE, SETUP, WSTROBE, WHOLD, RWAIT, DONE.
- IDLE:
  - On req=1 at an edge: latch we, req_addr, wdata; load mem_addr; go to SETUP.
  - On req=0: stay.
- SETUP (1 cycle): mem_addr stable, both strobes 0. Write goes to WSTROBE; read goes to RWAIT.
- WSTROBE: mem_write=1 for exactly STROBE_CYCLES cycles (down-counter), then WHOLD.
- WHOLD (1 cycle): mem_write=0; address and data held; then DONE.
- RWAIT: mem_read=1 for exactly READ_WAIT cycles. rdata captures mem_data on the clock edge that ends the last RWAIT cycle. Then DONE.
- DONE (1 cycle): ack=1, strobes 0, then IDLE.
- Latency (req sampled at edge N): write ack at cycle N+3+STROBE_CYCLES; read ack at cycle N+2+READ_WAIT. Defaults give write ack at N+4, read ack at N+3.
- Bus direction: mem_data is driven with the latched wdata only in SETUP, WSTROBE and WHOLD of a write; it is Z in every other state and whenever mem_read=1.
  - Hard rule: the master drive-enable and mem_read are never both 1.
- mem_read and mem_write are never both 1.
- mem_addr changes only in IDLE on acceptance. It holds its last value while idle.
- req while busy (including DONE) is ignored. There is no queueing; the requester holds req until it sees ack.
- Back-to-back: req held high through DONE is accepted in the following IDLE cycle.
- rdata is unchanged by write transactions.
- Reset mid-transaction: aborts immediately with all strobes dropped. A truncated write leaves memory content undefined at that address. No ack is issued.
- Parameters outside the legal range are a configuration error; flag with an elaboration-time check.

Decomposition:
- Shared defines file mem_bus_defs: state encodings (one-hot, 6 bits), default AWIDTH/DWIDTH.
- The same file is reused by the bench and the CPU controller.
- No sub-module: strobe counter and tri-state driver are inline.
- The bench instantiates the existing mem32x8 as the real responder.

Test Plan:
- Fill and readback: write addr i with data i for i = 0..31, then read 0..31 → each rdata == i at ack; write ack at N+4, read ack at N+3.
- Pattern: write 8'hA5 to addr 5'h1F and 8'h5A to addr 5'h00, read both → rdata 8'hA5 then 8'h5A; mem_data never X or contended during RWAIT.
- Busy-ignore: pulse req (write 8'hFF, addr 3) during an active read of addr 2 → only one ack; addr 3 unchanged when read back.
- Reset mid-write: deassert rst_ during WSTROBE → mem_write and busy fall asynchronously, mem_data goes Z, no ack; the next transaction completes normally.
- Parameter variant STROBE_CYCLES=3, READ_WAIT=2: write 8'h3C to addr 7 → mem_write high exactly 3 cycles, ack at N+6; read → mem_read high 2 cycles, ack at N+4, rdata 8'h3C.
- Assertions throughout all tests: mem_read and mem_write never both 1; master drive-enable and mem_read never both 1; ack is a single-cycle pulse.
